// File: rtl/delay_add_restore.sv
// delay_add_restore
//   Recursive inverse of the delay-subtract shaping filter:
//     Y[n] = sat(X[n] + (Y[n-d] >>> 1))
//   The feedback tap reads the filter's own output history. The loop gain is
//   1/2, so the loop is always stable. Saturated values are stored in the
//   history, so the feedback never carries a wrapped value.
//
// Ports
//   clk     system clock, rising edge
//   clr     asynchronous active-low reset
//   sclk    sample strobe; one sample per clk edge with sclk=1
//   X       signed delay-subtracted input sample
//   delay   feedback delay d in samples (0 disables feedback)
//   Y       registered restored sample
//   Yvalid  one-clk pulse after each processed strobe
//   sat     registered; set when the sample on Y was clipped
module delay_add_restore #(
  parameter int Nbits      = 14,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    sclk,
  input  logic signed [Nbits-1:0] X,
  input  logic [ADDR_WIDTH-1:0]   delay,
  output logic signed [Nbits-1:0] Y,
  output logic                    Yvalid,
  output logic                    sat
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // fill counter saturates at exactly DEPTH
  localparam logic [ADDR_WIDTH:0] FC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  // saturation bounds, expressed in the Nbits+1 sum width
  localparam logic signed [Nbits:0] MAXV = {2'b00, {(Nbits-1){1'b1}}};
  localparam logic signed [Nbits:0] MINV = {2'b11, {(Nbits-1){1'b0}}};

  logic signed [Nbits-1:0] hist [DEPTH];
  logic [ADDR_WIDTH-1:0]   wp;
  logic [ADDR_WIDTH:0]     fc;

  logic [ADDR_WIDTH-1:0]   raddr;
  logic signed [Nbits-1:0] fb;
  logic signed [Nbits:0]   sum;
  logic signed [Nbits-1:0] ynext;
  logic                    satnext;

  // modulo subtraction: the read address wraps together with wp
  assign raddr = wp - delay;

  // Gate feedback when the tap is disabled or points at a slot that has
  // not been written since reset (stale contents stay unobservable).
  always_comb begin
    fb = '0;
    if (delay != '0 && fc >= {1'b0, delay})
      fb = hist[raddr];
  end

  // fb >>> 1 done by sign-extending two bits and dropping the LSB (floors)
  assign sum = {X[Nbits-1], X} + {{2{fb[Nbits-1]}}, fb[Nbits-1:1]};

  always_comb begin
    ynext   = sum[Nbits-1:0];
    satnext = 1'b0;
    if (sum > MAXV) begin
      ynext   = MAXV[Nbits-1:0];
      satnext = 1'b1;
    end else if (sum < MINV) begin
      ynext   = MINV[Nbits-1:0];
      satnext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      Y      <= '0;
      sat    <= 1'b0;
      Yvalid <= 1'b0;
      wp     <= '0;
      fc     <= '0;
    end else begin
      Yvalid <= sclk;
      if (sclk) begin
        Y   <= ynext;
        sat <= satnext;
        wp  <= wp + 1'b1;
        if (fc != FC_FULL)
          fc <= fc + 1'b1;
      end
    end
  end

  // History RAM has no reset; a strobe while clr is low is ignored.
  always_ff @(posedge clk) begin
    if (clr && sclk)
      hist[wp] <= ynext;
  end

endmodule

// File: doc/delay_add_restore.md
# delay_add_restore

Recursive inverse of the delay-subtract shaping filter. It restores a sample stream from its delay-subtracted form by computing Y[n] = sat(X[n] + (Y[n-d] >>> 1)) over its own output history. It sits downstream of the delay-subtract stage in the filter chain and runs one update per sample strobe on the system clock. The loop gain is 1/2, so the filter is unconditionally stable.

## Interface
- Nbits, 14: sample width, signed two's complement, for X and Y.
- ADDR_WIDTH, 8: delay and history address width. History depth is 2^ADDR_WIDTH.

- clk  in  1  system clock; all state updates on its rising edge.
- clr  in  1  reset, asynchronous, active-low.
- sclk  in  1  sample strobe, synchronous to clk. One sample is processed per clk edge with sclk=1. It may be high on consecutive cycles.
- X  in  Nbits  signed delay-subtracted input sample, sampled when sclk=1.
- delay  in  ADDR_WIDTH  feedback delay d in samples; valid range 0..2^ADDR_WIDTH-1.
- Y  out  Nbits  signed restored sample, registered.
- Yvalid  out  1  one-clk pulse: Y was updated on the previous edge.
- sat  out  1  registered; 1 if the sample currently on Y was clipped.

## Operation
- State:
  - history array hist[0..2^ADDR_WIDTH-1] of Nbits;
  - write pointer wp, ADDR_WIDTH bits;
  - fill counter fc, ADDR_WIDTH+1 bits, saturating at 2^ADDR_WIDTH;
  - output registers Y, Yvalid, sat.
- Phases: FILL while fc < 2^ADDR_WIDTH, then RUN. FILL and RUN differ only in feedback gating.
- Feedback tap: fb = hist[wp - d], with modulo-2^ADDR_WIDTH subtraction and a combinational read.
  - fb is forced to 0 when d = 0.
  - fb is forced to 0 when fc < d, i.e. the tap points at a slot not yet written since reset.
- Sum: s = X + (fb >>> 1), computed in Nbits+1 signed bits.
  - >>> is an arithmetic shift and floors toward minus infinity: -3 >>> 1 = -2, -1 >>> 1 = -1.
- Saturation:
  - if s > 2^(Nbits-1)-1, Y = 2^(Nbits-1)-1 and sat = 1;
  - if s < -2^(Nbits-1), Y = -2^(Nbits-1) and sat = 1;
  - otherwise Y = s[Nbits-1:0] and sat = 0.
- On each clk edge with sclk=1:
  - Y and sat take the values above;
  - hist[wp] receives the new Y (the saturated value, so feedback never wraps);
  - wp increments, wrapping at 2^ADDR_WIDTH-1 -> 0;
  - fc increments unless already saturated;
  - Yvalid goes to 1.
- On a clk edge with sclk=0: Y, sat, wp, fc and hist hold; Yvalid goes to 0.
- With this ordering, d = k reads the output from exactly k strobes earlier (d = 1 gives the previous Y).
- Delay change: delay is sampled on every strobe edge and takes effect on that strobe. There is no flush; history is kept.
- Reset (clr=0, at any time including mid-stream):
  - immediately Y = 0, sat = 0, Yvalid = 0, wp = 0, fc = 0;
  - hist contents are not cleared (the fc gating makes them unobservable);
  - a strobe during reset is ignored.

## Timing
- Latency: the X sampled on edge n appears on Y after edge n, with Yvalid = 1 during cycle n+1.
- Throughput: one sample per clk maximum.
- The combinational path hist read -> add -> saturate -> Y register must close in one clk.
- Reset release: the first clk edge with clr=1 and sclk=1 processes normally, with fb = 0.
- Boundary cases:
  - wp wrap at 2^ADDR_WIDTH-1: the read address wp-d wraps the same way.
  - Maximum delay d = 2^ADDR_WIDTH-1: feedback is gated until 2^ADDR_WIDTH-1 samples have been written.

## Test plan
- Impulse: Nbits=14, d=4, one strobe with X=1000 then X=0 each strobe. Required Y: 1000,0,0,0,500,0,0,0,250,0,0,0,125, then 62, then 31; sat stays 0.
- Inverse check: bench generates s[n] (random, |s| < 2^12) and feeds X[n] = s[n] - (s[n-d] >>> 1), with s before reset taken as 0. Required: Y == s[n] bit-exact over 2000 strobes for each d in {1, 17, 255}.
- Saturation:
  - d=1, X=8191 on every strobe: Y = 8191 with sat=0 on the first strobe, then Y = 8191 with sat=1 thereafter.
  - Symmetric case X=-8192: Y = -8192, with sat=1 from the second strobe.
- Rounding, d=0 and idle cycles:
  - X=-3 then X=0 with d=1: Y = -3, then -2.
  - With d=0: Y = X every strobe.
  - With sclk=0 for 5 cycles: Y, sat and wp hold and Yvalid stays 0.
- Wrap and delay change: run 600 strobes at d=200 against a model, then switch to d=3 mid-stream. Y must match the model across the wp wrap and on the first strobe after the change.
- Reset mid-stream: assert clr=0 asynchronously between edges after 50 strobes.
  - Y, sat, Yvalid must go to 0 immediately.
  - After release, an impulse X=1000 at d=4 must reproduce the impulse sequence, with no stale history contribution.
